// File: rtl/ps2_keymap.sv
// PS/2 scancode-set-2 to character translator with break/extended prefix tracking,
// shift/ctrl/caps-lock modifiers and a one-deep valid/ready output register.
module ps2_keymap (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sym_data,
    input  logic       sym_valid,
    output logic       sym_ready,
    output logic [7:0] key_data,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       caps_lock
);

    typedef enum logic [1:0] {StIdle, StBrk, StExt, StExtBrk} state_e;

    state_e     state_q, state_d;
    logic       lshift_q, lshift_d, rshift_q, rshift_d, ctrl_q, ctrl_d;
    logic       caps_q, caps_d, caps_held_q, caps_held_d;
    logic       key_valid_q, key_valid_d, sym_ready_q, sym_ready_d;
    logic [7:0] key_data_q, key_data_d;

    logic       is_make, is_brk, is_ext, is_ignored;
    logic [8:0] xl;

    function automatic logic [7:0] pick(input logic shift, input logic [7:0] lo,
                                        input logic [7:0] hi);
        return shift ? hi : lo;
    endfunction

    // Returns {mapped, char} for a non-extended make.
    function automatic logic [8:0] xlate(input logic [7:0] code, input logic shift,
                                         input logic caps, input logic ctrl);
        logic [7:0] letter;
        logic [8:0] r;
        letter = 8'h00;
        r      = 9'h000;
        case (code)
            8'h1C: letter = "a";  8'h32: letter = "b";  8'h21: letter = "c";
            8'h23: letter = "d";  8'h24: letter = "e";  8'h2B: letter = "f";
            8'h34: letter = "g";  8'h33: letter = "h";  8'h43: letter = "i";
            8'h3B: letter = "j";  8'h42: letter = "k";  8'h4B: letter = "l";
            8'h3A: letter = "m";  8'h31: letter = "n";  8'h44: letter = "o";
            8'h4D: letter = "p";  8'h15: letter = "q";  8'h2D: letter = "r";
            8'h1B: letter = "s";  8'h2C: letter = "t";  8'h3C: letter = "u";
            8'h2A: letter = "v";  8'h1D: letter = "w";  8'h22: letter = "x";
            8'h35: letter = "y";  8'h1A: letter = "z";
            default: letter = 8'h00;
        endcase
        if (letter != 8'h00) begin
            if (ctrl)              r = {1'b1, letter & 8'h1F};
            else if (shift ^ caps) r = {1'b1, letter - 8'h20};
            else                   r = {1'b1, letter};
        end else begin
            case (code)
                8'h16: r = {1'b1, pick(shift, "1", "!")};
                8'h1E: r = {1'b1, pick(shift, "2", "@")};
                8'h26: r = {1'b1, pick(shift, "3", "#")};
                8'h25: r = {1'b1, pick(shift, "4", "$")};
                8'h2E: r = {1'b1, pick(shift, "5", "%")};
                8'h36: r = {1'b1, pick(shift, "6", "^")};
                8'h3D: r = {1'b1, pick(shift, "7", "&")};
                8'h3E: r = {1'b1, pick(shift, "8", "*")};
                8'h46: r = {1'b1, pick(shift, "9", "(")};
                8'h45: r = {1'b1, pick(shift, "0", ")")};
                8'h4E: r = {1'b1, pick(shift, "-", "_")};
                8'h55: r = {1'b1, pick(shift, "=", "+")};
                8'h54: r = {1'b1, pick(shift, "[", "{")};
                8'h5B: r = {1'b1, pick(shift, "]", "}")};
                8'h5D: r = {1'b1, pick(shift, 8'h5C, "|")};
                8'h4C: r = {1'b1, pick(shift, ";", ":")};
                8'h52: r = {1'b1, pick(shift, 8'h27, 8'h22)};
                8'h0E: r = {1'b1, pick(shift, 8'h60, "~")};
                8'h41: r = {1'b1, pick(shift, ",", "<")};
                8'h49: r = {1'b1, pick(shift, ".", ">")};
                8'h4A: r = {1'b1, pick(shift, "/", "?")};
                8'h29: r = 9'h120;
                8'h5A: r = 9'h10D;
                8'h66: r = 9'h108;
                8'h0D: r = 9'h109;
                8'h76: r = 9'h11B;
                default: r = 9'h000;
            endcase
        end
        return r;
    endfunction

    function automatic logic [8:0] xlate_ext(input logic [7:0] code);
        case (code)
            8'h75:   return 9'h180;
            8'h72:   return 9'h181;
            8'h6B:   return 9'h182;
            8'h74:   return 9'h183;
            8'h71:   return 9'h17F;
            8'h5A:   return 9'h10D;
            default: return 9'h000;
        endcase
    endfunction

    always_comb begin
        is_ignored = (sym_data == 8'h00) || (sym_data == 8'hAA) || (sym_data == 8'hEE) ||
                     (sym_data == 8'hFA) || (sym_data == 8'hFC) || (sym_data == 8'hFE) ||
                     (sym_data == 8'hFF);
    end

    always_comb begin
        state_d     = state_q;
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        ctrl_d      = ctrl_q;
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
        key_valid_d = key_valid_q;
        key_data_d  = key_data_q;
        is_make     = 1'b0;
        is_brk      = 1'b0;
        is_ext      = 1'b0;
        xl          = 9'h000;

        if (key_valid_q && key_ready) key_valid_d = 1'b0;

        if (sym_valid && sym_ready_q) begin
            if (is_ignored) begin
                state_d = StIdle;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (sym_data == 8'hF0)      state_d = StBrk;
                        else if (sym_data == 8'hE0) state_d = StExt;
                        else                        is_make = 1'b1;
                    end
                    StBrk: begin
                        is_brk  = 1'b1;
                        state_d = StIdle;
                    end
                    StExt: begin
                        if (sym_data == 8'hF0) begin
                            state_d = StExtBrk;
                        end else begin
                            is_make = 1'b1;
                            is_ext  = 1'b1;
                            state_d = StIdle;
                        end
                    end
                    default: begin
                        is_brk  = 1'b1;
                        is_ext  = 1'b1;
                        state_d = StIdle;
                    end
                endcase
            end
        end

        if (is_make || is_brk) begin
            // Extended 12/59 are fake shifts and must not touch shift state.
            if (!is_ext) begin
                case (sym_data)
                    8'h12: lshift_d = is_make;
                    8'h59: rshift_d = is_make;
                    8'h58: begin
                        if (is_make) begin
                            if (!caps_held_q) caps_d = ~caps_q;
                            caps_held_d = 1'b1;
                        end else begin
                            caps_held_d = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            if (sym_data == 8'h14) ctrl_d = is_make;
        end

        if (is_make) begin
            xl = is_ext ? xlate_ext(sym_data) : xlate(sym_data, lshift_q | rshift_q, caps_q, ctrl_q);
            if (xl[8]) begin
                key_valid_d = 1'b1;
                key_data_d  = xl[7:0];
            end
        end

        sym_ready_d = ~key_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            ctrl_q      <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
            key_valid_q <= 1'b0;
            key_data_q  <= 8'h00;
            sym_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            ctrl_q      <= ctrl_d;
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
            key_valid_q <= key_valid_d;
            key_data_q  <= key_data_d;
            sym_ready_q <= sym_ready_d;
        end
    end

    assign sym_ready = sym_ready_q;
    assign key_valid = key_valid_q;
    assign key_data  = key_data_q;
    assign caps_lock = caps_q;

endmodule

// File: tb/tb_ps2_keymap.sv
// Directed bench for ps2_keymap: each task drives a scenario and checks outputs inline.
module tb_ps2_keymap;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sym_data = 8'h00;
    logic       sym_valid = 1'b0;
    logic       sym_ready;
    logic [7:0] key_data;
    logic       key_valid;
    logic       key_ready = 1'b1;
    logic       caps_lock;

    int checks = 0;
    int errors = 0;
    logic [7:0] got[$];

    ps2_keymap dut (
        .clk       (clk),
        .rst       (rst),
        .sym_data  (sym_data),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .key_data  (key_data),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .caps_lock (caps_lock)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && key_valid && key_ready) got.push_back(key_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        while (!sym_ready && n < 20) begin
            tick();
            n++;
        end
        if (!sym_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: sym_ready=%b required 1 (byte %h)", sym_ready, b);
        end
        sym_data  = b;
        sym_valid = 1'b1;
        tick();
        sym_valid = 1'b0;
    endtask

    task automatic flush();
        repeat (3) tick();
    endtask

    task automatic check_q(input string name, input int n, input logic [7:0] c0,
                           input logic [7:0] c1);
        checks++;
        if (got.size() !== n) begin
            errors++;
            $display("FAIL %s_count: got %0d chars required %0d", name, got.size(), n);
        end else if ((n > 0 && got[0] !== c0) || (n > 1 && got[1] !== c1)) begin
            errors++;
            $display("FAIL %s_data: got %h %h required %h %h", name, got[0],
                     (n > 1) ? got[1] : 8'h00, c0, c1);
        end
        got.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if ({key_valid, key_data, sym_ready, caps_lock} !== {1'b0, 8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset: kv=%b kd=%h sr=%b caps=%b required 0 00 1 0",
                     key_valid, key_data, sym_ready, caps_lock);
        end
        rst = 1'b0;
        tick();
        got.delete();
    endtask

    task automatic test_letter();
        send(8'h1C);
        checks++;
        if ({key_valid, key_data, sym_ready} !== {1'b1, 8'h61, 1'b0}) begin
            errors++;
            $display("FAIL letter_a: kv=%b kd=%h sr=%b required 1 61 0",
                     key_valid, key_data, sym_ready);
        end
        tick();
        checks++;
        if ({key_valid, sym_ready} !== 2'b01) begin
            errors++;
            $display("FAIL letter_pulse: kv=%b sr=%b required 0 1", key_valid, sym_ready);
        end
        send(8'hF0);
        checks++;
        if (sym_ready !== 1'b1) begin
            errors++;
            $display("FAIL prefix_ready: sr=%b required 1", sym_ready);
        end
        send(8'h1C);
        flush();
        check_q("letter_break", 1, 8'h61, 8'h00);
    endtask

    task automatic test_shift();
        send(8'h12); send(8'h16); send(8'hF0); send(8'h12); send(8'h16);
        flush();
        check_q("shift_digit", 2, 8'h21, 8'h31);
        send(8'h59); send(8'h4A); send(8'hF0); send(8'h59); send(8'h0E);
        flush();
        check_q("rshift_punct", 2, 8'h3F, 8'h60);
    endtask

    task automatic test_caps();
        send(8'h58); send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
        flush();
        check_q("caps_upper", 1, 8'h41, 8'h00);
        checks++;
        if (caps_lock !== 1'b1) begin
            errors++;
            $display("FAIL caps_led: caps=%b required 1", caps_lock);
        end
        send(8'h12); send(8'h1C); send(8'h16); send(8'hF0); send(8'h12);
        flush();
        check_q("caps_shift", 2, 8'h61, 8'h21);
        send(8'h58); send(8'hF0); send(8'h58);
        flush();
        checks++;
        if (caps_lock !== 1'b0) begin
            errors++;
            $display("FAIL caps_off: caps=%b required 0", caps_lock);
        end
    endtask

    task automatic test_ctrl_ext();
        send(8'h14); send(8'h21); send(8'hF0); send(8'h14); send(8'h21);
        flush();
        check_q("ctrl_c", 2, 8'h03, 8'h63);
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'h12);
        flush();
        check_q("ext_up", 1, 8'h80, 8'h00);
        send(8'h1C);
        flush();
        check_q("fake_shift", 1, 8'h61, 8'h00);
        send(8'hE0); send(8'h6B); send(8'h29);
        flush();
        check_q("ext_left_space", 2, 8'h82, 8'h20);
        send(8'hE0); send(8'h14); send(8'h32); send(8'hE0); send(8'hF0); send(8'h14);
        send(8'h5A);
        flush();
        check_q("ectrl_enter", 2, 8'h02, 8'h0D);
    endtask

    task automatic test_back_to_back();
        key_ready = 1'b0;
        send(8'h1C);
        sym_data  = 8'h32;
        sym_valid = 1'b1;
        repeat (3) tick();
        checks++;
        if ({key_valid, key_data, sym_ready} !== {1'b1, 8'h61, 1'b0}) begin
            errors++;
            $display("FAIL stall_hold: kv=%b kd=%h sr=%b required 1 61 0",
                     key_valid, key_data, sym_ready);
        end
        key_ready = 1'b1;
        tick();
        checks++;
        if ({key_valid, sym_ready} !== 2'b01) begin
            errors++;
            $display("FAIL stall_release: kv=%b sr=%b required 0 1", key_valid, sym_ready);
        end
        tick();
        sym_valid = 1'b0;
        checks++;
        if ({key_valid, key_data} !== {1'b1, 8'h62}) begin
            errors++;
            $display("FAIL stall_next: kv=%b kd=%h required 1 62", key_valid, key_data);
        end
        flush();
        check_q("stall_order", 2, 8'h61, 8'h62);
    endtask

    task automatic test_reset_mid();
        key_ready = 1'b0;
        send(8'h1C);
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({key_valid, sym_ready} !== 2'b01) begin
            errors++;
            $display("FAIL async_drop: kv=%b sr=%b required 0 1", key_valid, sym_ready);
        end
        tick();
        rst = 1'b0;
        key_ready = 1'b1;
        tick();
        got.delete();
        send(8'hE0);
        #3 rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        send(8'h75);
        flush();
        check_q("rst_ext_cleared", 0, 8'h00, 8'h00);
        send(8'hAA);
        flush();
        check_q("ignored_aa", 0, 8'h00, 8'h00);
        send(8'hE0); send(8'hFA); send(8'h75);
        flush();
        check_q("ack_resets_fsm", 0, 8'h00, 8'h00);
    endtask

    initial begin
        test_reset();
        test_letter();
        test_shift();
        test_caps();
        test_ctrl_ext();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_keymap.md
# ps2_keymap

Converts the raw PS/2 scancode-set-2 byte stream from `ps2phy` into 8-bit key characters for the CPU keyboard port (`kb_data`/`kb_valid`/`kb_ready` on `core`). It tracks break (F0) and extended (E0) prefixes and modifier state: shift, ctrl and caps lock. It emits one character per make event on a one-deep valid/ready output register. It sits between `ps2phy` and `core` in `fpga_root`, in the `clk48` domain.

## Interface
Parameters: none.

Ports:
- `clk` input 1: system clock (48 MHz).
- `rst` input 1: reset. Asynchronous, active-high.
- `sym_data` input 8: scancode byte from `ps2phy`.
- `sym_valid` input 1: `sym_data` is valid.
- `sym_ready` output 1: block accepts `sym_data`.
- `key_data` output 8: translated character.
- `key_valid` output 1: `key_data` is valid.
- `key_ready` input 1: consumer accepts `key_data`.
- `caps_lock` output 1: current caps-lock state, for an LED.

## Operation
- Input transfer: occurs on a rising edge when `sym_valid & sym_ready`.
  - `sym_ready = ~key_valid`. It is driven from a flop only.
  - No input is accepted while an output is pending, even if the byte would produce no output.
- Prefix FSM states: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen).
  - IDLE: F0→BRK; E0→EXT; any other byte is processed as a make, stay IDLE.
  - BRK: byte processed as a break → IDLE.
  - EXT: F0→EXT_BRK; other byte processed as an extended make → IDLE.
  - EXT_BRK: byte processed as an extended break → IDLE.
  - Bytes 00, AA, EE, FA, FC, FE, FF in any state: no output, no modifier change, FSM → IDLE.
- Modifiers:
  - Make/break of 12 (left shift) sets/clears `lshift`.
  - Make/break of 59 (right shift) sets/clears `rshift`.
  - Make/break of 14 or E0 14 sets/clears `ctrl`.
  - Make of 58 toggles `caps_lock` only if `caps_held` is 0, then sets `caps_held`. Break of 58 clears `caps_held`, so typematic repeats do not re-toggle.
  - E0 12 and E0 59 (fake shifts) are ignored.
  - Modifier keys produce no output.
- Translation of a non-extended make (US layout; `shift = lshift|rshift`):
  - Letters (1C=a … 1A=z, standard set 2): lowercase if `shift ^ caps_lock` = 0, else uppercase.
    - If `ctrl` is set, output = letter & 0x1F (e.g., ctrl+c → 0x03), overriding shift/caps.
  - Digits 16,1E,26,25,2E,36,3D,3E,46,45 → '1'…'9','0'. With shift: `!@#$%^&*()`.
  - Punctuation 4E,55,54,5B,5D,4C,52,0E,41,49,4A → `- = [ ] \ ; ' \` , . /`. With shift: `_ + { } | : " ~ < > ?`.
  - Caps lock does not affect digits or punctuation.
  - 29→0x20, 5A→0x0D, 66→0x08, 0D→0x09, 76→0x1B.
- Translation of an extended make:
  - E0 75→0x80, E0 72→0x81, E0 6B→0x82, E0 74→0x83 (up/down/left/right).
  - E0 71→0x7F; E0 5A→0x0D.
- Unmapped makes, all breaks and other extended codes produce no output.
- Typematic repeats (repeated makes) each produce output.

## Timing
- Reset values: `key_valid`=0, `key_data`=0x00, `sym_ready`=1, `caps_lock`=0, all modifiers and `caps_held`=0, FSM=IDLE.
- Latency: a make accepted at edge N gives `key_valid`=1 with `key_data` stable after edge N. `sym_ready`=0 after the same edge.
- `key_data` and `key_valid` hold until an edge with `key_valid & key_ready`. After that edge `key_valid`=0 and `sym_ready`=1.
  - Peak throughput is one character per 2 cycles.
- Non-output bytes (prefixes, breaks, modifiers, unmapped codes) complete in 1 cycle. `sym_ready` stays 1.
- Reset asserted mid-sequence (e.g., after E0) clears the FSM and drops any pending character immediately.

## Test plan
- Reset, then feed 1C with `key_ready`=1 → one cycle later `key_data`=0x61, `key_valid`=1 for exactly 1 cycle. Then feed F0 1C → no output.
- Feed 12, 16, F0 12, 16 → outputs 0x21 then 0x31.
- Feed 58, 58, F0 58, 1C → one output, 0x41; `caps_lock`=1. Then 12, 1C → 0x61.
- Feed 14, 21, F0 14, 21 → 0x03 then 0x63. Feed E0 75, E0 F0 75, E0 12 → exactly one output, 0x80.
- Hold `key_ready`=0, feed 1C then 32 → `key_data` stays 0x61 and `sym_ready`=0. Release `key_ready` → 32 accepted, 0x62 follows. No byte is lost.
- Feed E0, assert `rst` asynchronously for 1 cycle, then feed 75 → output 0x80 is not produced (75 is unmapped as a non-extended make). Feed AA → no output.
